// File: rtl/stage_mem_if.sv
// ============================================================================
// Module  : stage_mem_if
// Brief   : Ready-handshaked data-memory port between the MEM stage and memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface stage_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

`default_nettype wire

// File: rtl/stage_mem.sv
// ============================================================================
// Module  : stage_mem
// Brief   : MIPS MEM stage - branch resolution, data-memory access with stall,
//           MEM/WB register. Optional access timeout: define MEM_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_mem #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire         clock,
    input  wire         reset,
    input  wire         nop,
    input  wire         is_jump,
    input  wire         branch_eq,
    input  wire         branch_inc,
    input  wire         zero,
    input  wire  [31:0] jump_address,
    input  wire  [1:0]  wbi,
    input  wire         M,
    input  wire  [4:0]  regaddr,
    input  wire  [31:0] data_b,
    input  wire  [31:0] alu_out,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        flush,
    output logic        stall,
    stage_mem_if.master mem,
    output logic [1:0]  wbi_o,
    output logic [31:0] read_data_o,
    output logic [31:0] alu_out_o,
    output logic [4:0]  regaddr_o,
    output logic        nop_o,
    output logic        mem_error
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_is_ctrl;
    logic        w_access;
    logic        w_is_load;
    logic        w_abort;
    logic        w_capture;

    logic [1:0]  r_wbi;
    logic [31:0] r_rdata;
    logic [31:0] r_alu;
    logic [4:0]  r_regaddr;
    logic        r_nop;

    // Branch/jump slots never touch memory, even if decode left M/MemToReg set.
    assign w_is_ctrl = is_jump | branch_eq | branch_inc;
    assign w_access  = !nop && !w_is_ctrl && (M || wbi[0]);
    assign w_is_load = w_access && !M;

    assign pc_src        = !reset && !nop &&
                           (is_jump || (branch_eq && zero) || (branch_inc && !zero));
    assign flush         = pc_src;
    assign branch_target = jump_address;

    assign mem.mem_we    = M;
    assign mem.mem_addr  = alu_out;
    assign mem.mem_wdata = data_b;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_mem_error;

    assign w_abort   = (r_state == S_WAIT) && !mem.mem_ready &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign mem_error = r_mem_error;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt       <= '0;
            r_mem_error <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_abort) begin
                r_mem_error <= 1'b1;
            end
        end
    end
`else
    // The timeout depth only matters when the counter is built.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_abort   = 1'b0;
    assign mem_error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem.mem_req = 1'b0;
        stall       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                mem.mem_req = w_access;
                stall       = w_access && !mem.mem_ready;
                w_capture   = !w_access || mem.mem_ready;
                if (w_access && !mem.mem_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                mem.mem_req = !w_abort;
                stall       = !mem.mem_ready && !w_abort;
                w_capture   = mem.mem_ready;
                if (mem.mem_ready || w_abort) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (reset) begin
            mem.mem_req = 1'b0;
            stall       = 1'b0;
        end
    end

    // A non-captured cycle writes a bubble so WB never sees a half-done access.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wbi     <= 2'b00;
            r_rdata   <= '0;
            r_alu     <= '0;
            r_regaddr <= '0;
            r_nop     <= 1'b1;
        end else if (w_capture) begin
            r_wbi     <= nop ? 2'b00 : wbi;
            r_rdata   <= w_is_load ? mem.mem_rdata : 32'h0;
            r_alu     <= alu_out;
            r_regaddr <= regaddr;
            r_nop     <= nop;
        end else begin
            r_wbi     <= 2'b00;
            r_rdata   <= '0;
            r_alu     <= '0;
            r_regaddr <= '0;
            r_nop     <= 1'b1;
        end
    end

    assign wbi_o       = r_wbi;
    assign read_data_o = r_rdata;
    assign alu_out_o   = r_alu;
    assign regaddr_o   = r_regaddr;
    assign nop_o       = r_nop;

endmodule

`default_nettype wire
